// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the RISC-V pipeline control blocks.
package riscv_pipe_pkg;

    localparam int REG_ADDR_W          = 5;
    localparam int MAX_LOAD_USE_STALLS = 4;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/load_use_scoreboard.sv
// Shift-register record of recent loads, one entry per cycle of load-to-use latency,
// plus the compare of the ID instruction's source registers against every live entry.
module load_use_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ins_vld,
    input  logic [REG_ADDR_W-1:0] ins_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic                  use_rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs2,
    output logic                  match
);

    logic [DEPTH-1:0]      vld_q;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    sb_entry_t             sb   [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= ins_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Register indices are qualified by vld, so they need no reset.
    always_ff @(posedge clk) begin
        rd_q[0] <= ins_rd;
        for (int i = 1; i < DEPTH; i++) begin
            rd_q[i] <= rd_q[i-1];
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb[i].vld = vld_q[i];
            sb[i].rd  = rd_q[i];
            if (sb[i].vld && ((use_rs1 && (rs1 == sb[i].rd)) ||
                              (use_rs2 && (rs2 == sb[i].rd)))) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush control for the ID stage.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module hazard_detection_unit
    import riscv_pipe_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    if ((LOAD_USE_STALLS < 1) || (LOAD_USE_STALLS > MAX_LOAD_USE_STALLS)) begin : g_bad_depth
        $error("hazard_detection_unit: LOAD_USE_STALLS=%0d outside 1..%0d",
               LOAD_USE_STALLS, MAX_LOAD_USE_STALLS);
    end

    logic match;
    logic hazard;
    logic ins_vld;

    // A stalled or squashed load never leaves ID this cycle, so it must not be recorded.
    assign ins_vld = id_valid && id_mem_read && (id_rd != '0) && !stall && !ex_branch_taken;

    load_use_scoreboard #(
        .DEPTH(LOAD_USE_STALLS)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .ins_vld(ins_vld),
        .ins_rd (id_rd),
        .rs1    (id_rs1),
        .use_rs1(id_uses_rs1),
        .rs2    (id_rs2),
        .use_rs2(id_uses_rs2),
        .match  (match)
    );

    assign hazard = id_valid && match;

    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ex_branch_taken && (flush_events != '1)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench driving a LOAD_USE_STALLS=1 and a LOAD_USE_STALLS=2 instance with shared stimulus.
module tb_hazard_detection_unit;

    localparam logic [4:0] OKV = 5'b01100;
    localparam logic [4:0] STV = 5'b10000;
    localparam logic [4:0] FLV = 5'b01111;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic [4:0] e1;
        logic [4:0] e2;
    } row_t;

    typedef struct {
        logic [4:0] e1;
        logic [4:0] e2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_mem_read;
    logic       ex_branch_taken;

    logic stall1, pcw1, ifw1, iff1, exf1;
    logic stall2, pcw2, ifw2, iff2, exf2;
    logic [4:0] outs1;
    logic [4:0] outs2;

    int checks = 0;
    int errors = 0;
    exp_t expq[$];

    assign outs1 = {stall1, pcw1, ifw1, iff1, exf1};
    assign outs2 = {stall2, pcw2, ifw2, iff2, exf2};

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles1, flush_events1, stall_cycles2, flush_events2;
`endif

    hazard_detection_unit #(.LOAD_USE_STALLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall(stall1), .pc_write(pcw1), .if_id_write(ifw1),
        .if_id_flush(iff1), .id_ex_flush(exf1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles1), .flush_events(flush_events1)
`endif
    );

    hazard_detection_unit #(.LOAD_USE_STALLS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall(stall2), .pc_write(pcw2), .if_id_write(ifw2),
        .if_id_flush(iff2), .id_ex_flush(exf2)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles2), .flush_events(flush_events2)
`endif
    );

    function automatic row_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic mr, logic br, logic [4:0] e1, logic [4:0] e2);
        row_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.mr = mr; r.br = br; r.e1 = e1; r.e2 = e2;
        return r;
    endfunction

    function automatic row_t ld(logic [4:0] rd, logic [4:0] e1, logic [4:0] e2);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, 1'b0, e1, e2);
    endfunction

    function automatic row_t alu(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] e1, logic [4:0] e2);
        return mk(1'b1, rs1, rs2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, e1, e2);
    endfunction

    function automatic row_t nop();
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, OKV, OKV);
    endfunction

    // Drives one ID-stage cycle, queues its expectation, and advances to the sampling edge.
    task automatic apply_row(input row_t r);
        exp_t e;
        id_valid        = r.v;
        id_rs1          = r.rs1;
        id_rs2          = r.rs2;
        id_uses_rs1     = r.u1;
        id_uses_rs2     = r.u2;
        id_rd           = r.rd;
        id_mem_read     = r.mr;
        ex_branch_taken = r.br;
        e.e1 = r.e1;
        e.e2 = r.e2;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_mem_read = 0; ex_branch_taken = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        apply_row(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, OKV, OKV));
        e = expq.pop_front();
        checks++;
        if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL reset n1: got %b expected %b", outs1, e.e1); end
        checks++;
        if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL reset n2: got %b expected %b", outs2, e.e2); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        rows.push_back(ld(5'd5, OKV, OKV));
        rows.push_back(alu(5'd5, 5'd1, STV, STV));
        rows.push_back(alu(5'd5, 5'd1, OKV, STV));
        rows.push_back(alu(5'd5, 5'd1, OKV, OKV));
        rows.push_back(ld(5'd5, OKV, OKV));
        rows.push_back(nop());
        rows.push_back(alu(5'd5, 5'd0, OKV, STV));
        rows.push_back(alu(5'd5, 5'd0, OKV, OKV));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = expq.pop_front();
            checks++;
            if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL load_use row %0d n1: got %b expected %b", i, outs1, e.e1); end
            checks++;
            if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL load_use row %0d n2: got %b expected %b", i, outs2, e.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0_and_use_bits();
        row_t rows[$];
        exp_t e;
        rows.push_back(ld(5'd0, OKV, OKV));
        rows.push_back(alu(5'd0, 5'd0, OKV, OKV));
        rows.push_back(ld(5'd3, OKV, OKV));
        rows.push_back(mk(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, OKV, OKV));
        rows.push_back(nop());
        rows.push_back(ld(5'd4, OKV, OKV));
        rows.push_back(mk(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, OKV, OKV));
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = expq.pop_front();
            checks++;
            if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL x0_use row %0d n1: got %b expected %b", i, outs1, e.e1); end
            checks++;
            if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL x0_use row %0d n2: got %b expected %b", i, outs2, e.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_priority();
        row_t rows[$];
        exp_t e;
        rows.push_back(ld(5'd5, OKV, OKV));
        rows.push_back(mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, FLV, FLV));
        rows.push_back(alu(5'd8, 5'd5, OKV, STV));
        rows.push_back(mk(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, OKV, OKV));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = expq.pop_front();
            checks++;
            if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL branch row %0d n1: got %b expected %b", i, outs1, e.e1); end
            checks++;
            if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL branch row %0d n2: got %b expected %b", i, outs2, e.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        rows.push_back(ld(5'd5, OKV, OKV));
        rows.push_back(ld(5'd6, OKV, OKV));
        rows.push_back(alu(5'd5, 5'd6, STV, STV));
        rows.push_back(alu(5'd5, 5'd6, OKV, STV));
        rows.push_back(alu(5'd5, 5'd6, OKV, OKV));
        rows.push_back(ld(5'd9, OKV, OKV));
        rows.push_back(mk(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, STV, STV));
        rows.push_back(mk(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, OKV, STV));
        rows.push_back(mk(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, OKV, OKV));
        rows.push_back(alu(5'd10, 5'd0, STV, STV));
        rows.push_back(alu(5'd10, 5'd0, OKV, STV));
        rows.push_back(alu(5'd10, 5'd0, OKV, OKV));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            e = expq.pop_front();
            checks++;
            if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL b2b row %0d n1: got %b expected %b", i, outs1, e.e1); end
            checks++;
            if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL b2b row %0d n2: got %b expected %b", i, outs2, e.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        apply_row(ld(5'd5, OKV, OKV));
        void'(expq.pop_front());
        @(posedge clk); #1;
        apply_row(alu(5'd5, 5'd1, STV, STV));
        e = expq.pop_front();
        checks++;
        if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL pre_reset n1: got %b expected %b", outs1, e.e1); end
        checks++;
        if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL pre_reset n2: got %b expected %b", outs2, e.e2); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs1 !== OKV) begin errors++; $display("[TB] FAIL async_reset n1: got %b expected %b", outs1, OKV); end
        checks++;
        if (outs2 !== OKV) begin errors++; $display("[TB] FAIL async_reset n2: got %b expected %b", outs2, OKV); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        apply_row(alu(5'd5, 5'd1, OKV, OKV));
        e = expq.pop_front();
        checks++;
        if (outs1 !== e.e1) begin errors++; $display("[TB] FAIL post_reset n1: got %b expected %b", outs1, e.e1); end
        checks++;
        if (outs2 !== e.e2) begin errors++; $display("[TB] FAIL post_reset n2: got %b expected %b", outs2, e.e2); end
        @(posedge clk); #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_counters();
        row_t rows[$];
        do_reset();
        checks++;
        if (stall_cycles1 !== 32'd0) begin errors++; $display("[TB] FAIL cnt_reset: got %0d expected 0", stall_cycles1); end
        rows.push_back(ld(5'd5, OKV, OKV));
        rows.push_back(alu(5'd5, 5'd0, STV, STV));
        rows.push_back(ld(5'd6, OKV, STV));
        rows.push_back(alu(5'd6, 5'd0, STV, STV));
        rows.push_back(ld(5'd7, OKV, STV));
        rows.push_back(alu(5'd7, 5'd0, STV, STV));
        rows.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, FLV, FLV));
        rows.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, FLV, FLV));
        rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            void'(expq.pop_front());
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles1 !== 32'd3) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected 3", stall_cycles1); end
        checks++;
        if (flush_events1 !== 32'd2) begin errors++; $display("[TB] FAIL flush_events: got %0d expected 2", flush_events1); end
    endtask
`endif

    initial begin
        $display("[TB] hazard_detection_unit bench start");
        test_reset();
        test_load_use();
        test_x0_and_use_bits();
        test_branch_priority();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_counters();
`endif
        checks++;
        if (expq.size() != 0) begin errors++; $display("[TB] FAIL queue_drain: got %0d expected 0", expq.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
